downscale_engine: RTL and testbench
===================================

Name: downscale_engine

Overview:
Parametrised image downscaler that reads a WIDTH x HEIGHT source frame from a synchronous ROM and writes a reduced frame into the VGA frame RAM.
- Runtime-selectable factor: 1, 2, 4 or 8.
- Two modes: nearest (pick the top-left pixel of each block) and block average (mean of each f x f block).
- Start/busy/done handshake, so a controller can re-run it on every factor or mode change.
- Configurable ROM read latency.
- Sits between the image ROM and the VGA RAM write port.

Parameters:
WIDTH, 160, source width in pixels; must be divisible by 8
HEIGHT, 120, source height in pixels; must be divisible by 8
PIX_W, 8, pixel width in bits
ADDR_W, 19, ROM and RAM address width
RD_LAT, 1, ROM read latency in cycles (1..3)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle request; accepted only in IDLE
factor_sel  in  2  00=1, 01=2, 10=4, 11=8; latched at start
mode  in  1  0=nearest, 1=average; latched at start
rom_addr  out  ADDR_W  source read address
pixel_rom  in  PIX_W  ROM data, valid RD_LAT cycles after rom_addr
ram_we  out  1  write strobe to VGA RAM
addr_ram_vga  out  ADDR_W  destination address
pixel_saida  out  PIX_W  destination data
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle completion pulse

Behaviour:
- Reset, applied on any clk edge with rst=1: state=IDLE; rom_addr=0, addr_ram_vga=0, pixel_saida=0; ram_we=0, busy=0, done=0; all counters and the accumulator cleared. Reset mid-operation aborts the frame; no further ram_we pulses occur.
- f = 1<<factor_sel. Output size is OW=WIDTH/f by OH=HEIGHT/f. Output address = oy*OW + ox, written in raster order.
- State machine IDLE -> RUN -> DRAIN -> DONE -> IDLE.
  - IDLE: start=1 latches f and mode, clears counters, goes to RUN. Inputs are otherwise ignored.
  - RUN: issues one ROM address per cycle, no stalls.
    - Nearest: one read per output pixel at (oy*f)*WIDTH + ox*f.
    - Average: f*f reads per output pixel, iterating sx fastest, then sy, then ox, then oy; address (oy*f+sy)*WIDTH + ox*f+sx.
    - After the last address is issued, go to DRAIN.
  - DRAIN: waits RD_LAT cycles for the final returns, then goes to DONE.
  - DONE: done=1 and busy=0 for one cycle, then IDLE.
- start, factor_sel and mode are ignored while busy.
- Return alignment: a valid/last tag shift register of depth RD_LAT travels with each issued address.
  - Nearest: every return produces ram_we=1 on the following cycle, with pixel_saida = pixel_rom.
  - Average: returns add into an accumulator of width PIX_W+6.
    - The accumulator clears on the first sample of each block.
    - On the last sample of a block, ram_we=1 on the following cycle with pixel_saida = (sum + sample) >> (2*factor_sel). Truncating division, no rounding.
- With f=1 both modes degenerate to a copy: WIDTH*HEIGHT writes, pixel_saida = source pixel.
- Write count per frame is exactly OW*OH. addr_ram_vga increments by 1 per write, starting at 0.
- Latency: first rom_addr is valid in the cycle after start. The last ram_we occurs RD_LAT+1 cycles after the last address is issued. done occurs in the cycle after the last ram_we.
- ram_we is a single-cycle strobe per write; addr_ram_vga and pixel_saida hold their values between writes.

Decomposition:
- Package downscale_pkg holds:
  - state enum (IDLE, RUN, DRAIN, DONE);
  - factor_sel encodings;
  - ACC_W = PIX_W+6;
  - constant MAX_LOG2F = 3.
- One sub-module, downscale_addr_gen, holds the ox/oy/sx/sy counters, the source address computation, and the first/last-of-block and last-of-frame flags.
- Return alignment, accumulator and write logic stay in the top.

Test Plan:
Bench uses WIDTH=16, HEIGHT=8, RD_LAT=2, and a ROM model returning pixel = addr[7:0].
- Nearest, f=2 -> 32 writes. Checkpoints: addr 0 = 0, addr 1 = 2, addr 8 = 32, addr 31 = 110. done pulses once, the cycle after the last write.
- Average, f=2 -> addr 0 = (0+1+16+17)>>2 = 8; addr 1 = (2+3+18+19)>>2 = 10; 32 writes total.
- Average, f=8, ROM constant 255 -> 2 writes, both 255. The accumulator reaches 16320 with no overflow.
- f=1, either mode -> 128 writes with data == address. First rom_addr is valid 1 cycle after start; first ram_we is 3 cycles after that.
- start pulsed with a different factor_sel while busy -> ignored; run completes with the original factor and write count.
- rst asserted mid-RUN for 1 cycle -> next cycle all outputs are 0, no ram_we follows, busy=0. A subsequent start performs a full, correct frame.

Source files
------------

// File: rtl/downscale_pkg.sv
// Shared types and constants for the frame downscaler: FSM states, factor
// encodings, return-tag layout and accumulator sizing.
package downscale_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    typedef enum logic [1:0] {
        FSEL_1 = 2'b00,
        FSEL_2 = 2'b01,
        FSEL_4 = 2'b10,
        FSEL_8 = 2'b11
    } fsel_e;

    localparam int MAX_LOG2F = 3;

    // A full 8x8 block sum needs 2*MAX_LOG2F extra bits above the pixel.
    function automatic int acc_w(input int pix_w);
        return pix_w + 2 * MAX_LOG2F;
    endfunction

    typedef struct packed {
        logic vld;
        logic first;
        logic last;
    } tag_t;

endpackage

// File: rtl/downscale_engine_if.sv
// Control handshake plus ROM read and VGA RAM write buses of the downscaler.
interface downscale_engine_if #(
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 19
);
    logic              start;
    logic [1:0]        factor_sel;
    logic              mode;
    logic [ADDR_W-1:0] rom_addr;
    logic [PIX_W-1:0]  pixel_rom;
    logic              ram_we;
    logic [ADDR_W-1:0] addr_ram_vga;
    logic [PIX_W-1:0]  pixel_saida;
    logic              busy;
    logic              done;

    modport master (
        output start, factor_sel, mode, pixel_rom,
        input  rom_addr, ram_we, addr_ram_vga, pixel_saida, busy, done
    );

    modport slave (
        input  start, factor_sel, mode, pixel_rom,
        output rom_addr, ram_we, addr_ram_vga, pixel_saida, busy, done
    );
endinterface

// File: rtl/downscale_addr_gen.sv
// Block/output-pixel counters and source address generation; sx fastest,
// then sy, ox, oy. Nearest mode collapses the block to a single sample.
module downscale_addr_gen
    import downscale_pkg::*;
#(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 120,
    parameter int ADDR_W = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              adv,
    input  logic [1:0]        fsel,
    input  logic              avg,
    output logic [ADDR_W-1:0] addr,
    output logic              first,
    output logic              last_blk,
    output logic              last_frame
);
    localparam int OX_W = $clog2(WIDTH);
    localparam int OY_W = $clog2(HEIGHT);

    logic [MAX_LOG2F-1:0] sx_q, sx_d, sy_q, sy_d, blk_max;
    logic [OX_W-1:0]      ox_q, ox_d, ow_max;
    logic [OY_W-1:0]      oy_q, oy_d, oh_max;
    logic [1:0]           blk_log2;
    logic                 sx_last, sy_last, ox_last, oy_last;
    logic [ADDR_W-1:0]    row, col;

    assign blk_log2 = avg ? fsel : 2'd0;
    assign blk_max  = 3'((4'd1 << blk_log2) - 4'd1);
    assign ow_max   = OX_W'((WIDTH >> fsel) - 1);
    assign oh_max   = OY_W'((HEIGHT >> fsel) - 1);

    assign sx_last    = (sx_q == blk_max);
    assign sy_last    = (sy_q == blk_max);
    assign ox_last    = (ox_q == ow_max);
    assign oy_last    = (oy_q == oh_max);
    assign first      = (sx_q == '0) && (sy_q == '0);
    assign last_blk   = sx_last && sy_last;
    assign last_frame = last_blk && ox_last && oy_last;

    assign row  = (ADDR_W'(oy_q) << fsel) + ADDR_W'(sy_q);
    assign col  = (ADDR_W'(ox_q) << fsel) + ADDR_W'(sx_q);
    assign addr = ADDR_W'(row * ADDR_W'(WIDTH)) + col;

    always_comb begin
        sx_d = sx_q;
        sy_d = sy_q;
        ox_d = ox_q;
        oy_d = oy_q;
        if (clr) begin
            sx_d = '0;
            sy_d = '0;
            ox_d = '0;
            oy_d = '0;
        end else if (adv) begin
            // All counters wrap to zero after the final sample of the frame.
            if (!sx_last) sx_d = sx_q + 3'd1;
            else begin
                sx_d = '0;
                if (!sy_last) sy_d = sy_q + 3'd1;
                else begin
                    sy_d = '0;
                    if (!ox_last) ox_d = ox_q + OX_W'(1);
                    else begin
                        ox_d = '0;
                        oy_d = oy_last ? '0 : oy_q + OY_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sx_q <= '0;
            sy_q <= '0;
            ox_q <= '0;
            oy_q <= '0;
        end else begin
            sx_q <= sx_d;
            sy_q <= sy_d;
            ox_q <= ox_d;
            oy_q <= oy_d;
        end
    end
endmodule

// File: rtl/downscale_engine.sv
// Frame downscaler: streams source reads from a latency-RD_LAT ROM and writes
// nearest or block-averaged pixels to the VGA RAM in raster order.
module downscale_engine
    import downscale_pkg::*;
#(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 120,
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 19,
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    downscale_engine_if.slave bus
);
    localparam int ACC_W = acc_w(PIX_W);

    state_e                 state_q, state_d;
    logic [1:0]             fsel_q, fsel_d, drn_q, drn_d;
    logic                   mode_q, mode_d, busy_q, busy_d, done_q, done_d;
    logic                   ram_we_q, ram_we_d;
    logic [ACC_W-1:0]       acc_q, acc_d, sum;
    logic [ADDR_W-1:0]      wr_cnt_q, wr_cnt_d, addr_ram_vga_q, addr_ram_vga_d, src_addr;
    logic [PIX_W-1:0]       pixel_saida_q, pixel_saida_d;
    tag_t [RD_LAT:1]        tag_pipe_q, tag_pipe_d;
    tag_t                   issue_tag, ret;
    logic                   start_acc, issue, gen_first, gen_last_blk, gen_last_frame;
    logic [2:0]             shamt;

    assign start_acc = (state_q == IDLE) && bus.start;
    assign issue     = (state_q == RUN);
    assign issue_tag = '{vld: issue, first: gen_first, last: gen_last_blk};
    assign ret       = tag_pipe_q[RD_LAT];
    assign sum       = (ret.first ? '0 : acc_q) + ACC_W'(bus.pixel_rom);
    assign shamt     = mode_q ? {fsel_q, 1'b0} : 3'd0;

    downscale_addr_gen #(
        .WIDTH (WIDTH),
        .HEIGHT(HEIGHT),
        .ADDR_W(ADDR_W)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .clr       (start_acc),
        .adv       (issue),
        .fsel      (fsel_q),
        .avg       (mode_q),
        .addr      (src_addr),
        .first     (gen_first),
        .last_blk  (gen_last_blk),
        .last_frame(gen_last_frame)
    );

    always_comb begin
        state_d        = state_q;
        fsel_d         = fsel_q;
        mode_d         = mode_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        drn_d          = drn_q;
        acc_d          = acc_q;
        wr_cnt_d       = wr_cnt_q;
        ram_we_d       = 1'b0;
        addr_ram_vga_d = addr_ram_vga_q;
        pixel_saida_d  = pixel_saida_q;
        tag_pipe_d[1]  = issue_tag;
        for (int i = 2; i <= RD_LAT; i++) tag_pipe_d[i] = tag_pipe_q[i-1];

        case (state_q)
            IDLE: if (bus.start) begin
                state_d  = RUN;
                fsel_d   = bus.factor_sel;
                mode_d   = bus.mode;
                busy_d   = 1'b1;
                wr_cnt_d = '0;
            end
            RUN: if (gen_last_frame) begin
                state_d = DRAIN;
                drn_d   = '0;
            end
            // RD_LAT cycles of ROM returns plus the registered write stage.
            DRAIN: if (drn_q == 2'(RD_LAT)) begin
                state_d = DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end else begin
                drn_d = drn_q + 2'd1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (ret.vld) begin
            acc_d = sum;
            if (ret.last) begin
                ram_we_d       = 1'b1;
                pixel_saida_d  = PIX_W'(sum >> shamt);
                addr_ram_vga_d = wr_cnt_q;
                wr_cnt_d       = wr_cnt_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            fsel_q         <= '0;
            mode_q         <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            drn_q          <= '0;
            acc_q          <= '0;
            wr_cnt_q       <= '0;
            ram_we_q       <= 1'b0;
            addr_ram_vga_q <= '0;
            pixel_saida_q  <= '0;
            tag_pipe_q     <= '0;
        end else begin
            state_q        <= state_d;
            fsel_q         <= fsel_d;
            mode_q         <= mode_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            drn_q          <= drn_d;
            acc_q          <= acc_d;
            wr_cnt_q       <= wr_cnt_d;
            ram_we_q       <= ram_we_d;
            addr_ram_vga_q <= addr_ram_vga_d;
            pixel_saida_q  <= pixel_saida_d;
            tag_pipe_q     <= tag_pipe_d;
        end
    end

    assign bus.rom_addr     = src_addr;
    assign bus.ram_we       = ram_we_q;
    assign bus.addr_ram_vga = addr_ram_vga_q;
    assign bus.pixel_saida  = pixel_saida_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
endmodule

// File: tb/tb_downscale_engine.sv
// Self-checking bench: 16x8 frame, RD_LAT=2, checkpoint table, hand-written
// corner sequences and randomized frames against a block-level reference.
module tb_downscale_engine;
    localparam int W = 16;
    localparam int H = 8;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    downscale_engine_if #(.PIX_W(8), .ADDR_W(19)) bus ();

    downscale_engine #(
        .WIDTH(W), .HEIGHT(H), .PIX_W(8), .ADDR_W(19), .RD_LAT(LAT)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    logic [7:0] mem [0:W*H-1];
    logic [7:0] rd1, rd2;
    always @(posedge clk) begin
        rd1 <= mem[bus.rom_addr[6:0]];
        rd2 <= rd1;
    end
    assign bus.pixel_rom = rd2;

    typedef struct {int addr; int data; int cyc;} wr_t;
    wr_t wr_q[$];
    int  cyc = 0;
    int  done_cnt = 0, done_cyc = 0;
    bit  busy_at_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (bus.ram_we) wr_q.push_back('{int'(bus.addr_ram_vga), int'(bus.pixel_saida), cyc});
        if (bus.done) begin
            done_cnt     <= done_cnt + 1;
            done_cyc     <= cyc;
            busy_at_done <= bus.busy;
        end
    end

    int n_chk = 0, n_pass = 0;
    function automatic void chk(input bit ok, input string nm, input int act, input int exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endfunction

    task automatic load(input int pat);
        for (int i = 0; i < W*H; i++)
            mem[i] = (pat == 0) ? 8'(i) : (pat == 1) ? 8'hFF : 8'($urandom);
    endtask

    // Reference: nearest picks the block's top-left pixel, average is the
    // truncated mean of the f x f block.
    function automatic int exp_pix(input int fs, input int md, input int idx);
        int f, ow, oy, ox, s;
        f = 1 << fs; ow = W / f; oy = idx / ow; ox = idx % ow; s = 0;
        if (md == 0) return int'(mem[oy*f*W + ox*f]);
        for (int sy = 0; sy < f; sy++)
            for (int sx = 0; sx < f; sx++)
                s += int'(mem[(oy*f + sy)*W + ox*f + sx]);
        return s / (f*f);
    endfunction

    int wr_base, done_base, start_cyc;

    task automatic run_frame(input int fs, input int md, input bit poke);
        int n, a0, a1;
        wr_base = wr_q.size(); done_base = done_cnt;
        @(negedge clk);
        bus.start = 1'b1; bus.factor_sel = 2'(fs); bus.mode = md[0]; start_cyc = cyc;
        @(negedge clk);
        bus.start = 1'b0; bus.factor_sel = 2'($urandom); bus.mode = 1'($urandom);
        a0 = int'(bus.rom_addr);
        chk(bus.busy == 1'b1, "busy_after_start", int'(bus.busy), 1);
        @(negedge clk);
        a1 = int'(bus.rom_addr);
        chk(a0 == 0, "first_rom_addr", a0, 0);
        chk(a1 == ((md != 0 && fs != 0) ? 1 : (1 << fs)), "second_rom_addr", a1,
            (md != 0 && fs != 0) ? 1 : (1 << fs));
        if (poke) begin
            repeat (5) @(negedge clk);
            bus.start = 1'b1; bus.factor_sel = ~2'(fs); bus.mode = ~md[0];
            @(negedge clk);
            bus.start = 1'b0;
        end
        n = 0;
        while (done_cnt == done_base && n < 2000) begin @(posedge clk); n++; end
        chk(n < 2000, "done_timeout", n, 2000);
        repeat (6) @(negedge clk);
    endtask

    task automatic check_frame(input int fs, input int md, input string tag);
        int n, sz, last_cyc;
        n = (W*H) >> (2*fs);
        sz = wr_q.size() - wr_base;
        chk(sz == n, {tag, "_write_count"}, sz, n);
        for (int i = 0; i < sz && i < n; i++) begin
            chk(wr_q[wr_base+i].addr == i, {tag, "_addr"}, wr_q[wr_base+i].addr, i);
            chk(wr_q[wr_base+i].data == exp_pix(fs, md, i), {tag, "_data"},
                wr_q[wr_base+i].data, exp_pix(fs, md, i));
        end
        last_cyc = (sz > 0) ? wr_q[wr_q.size()-1].cyc : -100;
        chk(done_cnt - done_base == 1, {tag, "_done_pulses"}, done_cnt - done_base, 1);
        chk(done_cyc == last_cyc + 1, {tag, "_done_after_last_write"}, done_cyc - last_cyc, 1);
        chk(busy_at_done == 1'b0, {tag, "_busy_at_done"}, int'(busy_at_done), 0);
    endtask

    typedef struct {int fs; int md; int pat; int idx; int pix; int cnt;} vec_t;
    vec_t tbl[11];

    initial begin
        int sz, late, rst_cyc;
        tbl[0]  = '{1, 0, 0, 0,  0,   32};
        tbl[1]  = '{1, 0, 0, 1,  2,   32};
        tbl[2]  = '{1, 0, 0, 8,  32,  32};
        tbl[3]  = '{1, 0, 0, 31, 110, 32};
        tbl[4]  = '{1, 1, 0, 0,  8,   32};
        tbl[5]  = '{1, 1, 0, 1,  10,  32};
        tbl[6]  = '{3, 1, 1, 1,  255, 2};
        tbl[7]  = '{0, 1, 0, 77, 77,  128};
        tbl[8]  = '{0, 0, 0, 127, 127, 128};
        tbl[9]  = '{2, 1, 0, 0,  25,  8};
        tbl[10] = '{3, 0, 0, 1,  8,   2};

        bus.start = 1'b0; bus.factor_sel = 2'd0; bus.mode = 1'b0;
        load(0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk(bus.ram_we == 1'b0, "reset_ram_we", int'(bus.ram_we), 0);
        chk(bus.busy == 1'b0, "reset_busy", int'(bus.busy), 0);
        chk(bus.done == 1'b0, "reset_done", int'(bus.done), 0);
        chk(bus.rom_addr == '0, "reset_rom_addr", int'(bus.rom_addr), 0);
        chk(bus.addr_ram_vga == '0, "reset_addr_ram_vga", int'(bus.addr_ram_vga), 0);
        chk(bus.pixel_saida == '0, "reset_pixel_saida", int'(bus.pixel_saida), 0);

        foreach (tbl[k]) begin
            load(tbl[k].pat);
            run_frame(tbl[k].fs, tbl[k].md, 1'b0);
            sz = wr_q.size() - wr_base;
            chk(sz == tbl[k].cnt, "tbl_count", sz, tbl[k].cnt);
            if (tbl[k].idx < sz) begin
                chk(wr_q[wr_base+tbl[k].idx].addr == tbl[k].idx, "tbl_addr",
                    wr_q[wr_base+tbl[k].idx].addr, tbl[k].idx);
                chk(wr_q[wr_base+tbl[k].idx].data == tbl[k].pix, "tbl_pix",
                    wr_q[wr_base+tbl[k].idx].data, tbl[k].pix);
            end else chk(1'b0, "tbl_idx_missing", sz, tbl[k].idx + 1);
        end

        // f=1 copy: first write 4 cycles after the start cycle.
        load(0);
        run_frame(0, 0, 1'b0);
        check_frame(0, 0, "copy");
        late = (wr_q.size() > wr_base) ? wr_q[wr_base].cyc - start_cyc : -1;
        chk(late == 4, "first_write_latency", late, 4);

        // start with another factor while busy must be ignored.
        load(2);
        run_frame(1, 0, 1'b1);
        check_frame(1, 0, "busy_start");

        // Reset in the middle of RUN aborts the frame.
        load(0);
        @(negedge clk);
        bus.start = 1'b1; bus.factor_sel = 2'd0; bus.mode = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; rst_cyc = cyc; done_base = done_cnt;
        chk(bus.ram_we == 1'b0, "midrst_ram_we", int'(bus.ram_we), 0);
        chk(bus.busy == 1'b0, "midrst_busy", int'(bus.busy), 0);
        chk(bus.rom_addr == '0 && bus.addr_ram_vga == '0 && bus.pixel_saida == '0,
            "midrst_outputs_zero", int'(bus.rom_addr) + int'(bus.addr_ram_vga) + int'(bus.pixel_saida), 0);
        repeat (12) @(negedge clk);
        late = 0;
        foreach (wr_q[i]) if (wr_q[i].cyc >= rst_cyc) late++;
        chk(late == 0, "midrst_no_writes", late, 0);
        chk(done_cnt == done_base, "midrst_no_done", done_cnt - done_base, 0);
        load(2);
        run_frame(0, 1, 1'b0);
        check_frame(0, 1, "after_rst");

        for (int r = 0; r < 6; r++) begin
            int fs, md;
            fs = $urandom_range(0, 3);
            md = $urandom_range(0, 1);
            load(2);
            run_frame(fs, md, 1'b0);
            check_frame(fs, md, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
